// File: rtl/debounce_sync_if.sv
// Signal bundle for debounce_sync: raw input level plus the conditioned outputs.
// The master drives din; the slave (the debouncer) drives the rest.
interface debounce_sync_if;
    logic din;
    logic dout;
    logic rise;
    logic fall;
    logic busy;

    modport master (output din, input dout, rise, fall, busy);
    modport slave  (input din, output dout, rise, fall, busy);
endinterface

// File: rtl/debounce_sync.sv
// Synchronises an asynchronous level into clk, then accepts a new level only after
// STABLE_CYCLES consecutive identical samples; emits one-cycle rise/fall strobes.
//
// state         | meaning
// ST_LOW        | dout=0, synchronised input steady low
// ST_CHECK_HIGH | dout=0, qualifying a candidate high level
// ST_HIGH       | dout=1, synchronised input steady high
// ST_CHECK_LOW  | dout=1, qualifying a candidate low level
module debounce_sync #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_WIDTH     = 8
) (
    input logic             clk,
    input logic             reset,
    debounce_sync_if.slave  io
);

    typedef enum logic [1:0] {
        ST_LOW        = 2'd0,
        ST_CHECK_HIGH = 2'd1,
        ST_HIGH       = 2'd2,
        ST_CHECK_LOW  = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    state_t                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   dout_q, dout_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   busy_q, busy_d;
    logic                   s;

    assign sync_d = {sync_q[SYNC_STAGES-2:0], io.din};
    assign s      = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        unique case (state_q)
            ST_LOW: begin
                if (s) begin
                    state_d = ST_CHECK_HIGH;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = '0;
                end
            end
            ST_CHECK_HIGH: begin
                if (!s) begin
                    state_d = ST_LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_HIGH;
                    dout_d  = 1'b1;
                    rise_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            ST_HIGH: begin
                if (!s) begin
                    state_d = ST_CHECK_LOW;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = '0;
                end
            end
            ST_CHECK_LOW: begin
                if (s) begin
                    state_d = ST_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_LOW;
                    dout_d  = 1'b0;
                    fall_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_LOW;
                cnt_d   = '0;
                dout_d  = 1'b0;
            end
        endcase
        // busy follows the state being entered so it stays aligned with dout/strobes
        busy_d = (state_d == ST_CHECK_HIGH) || (state_d == ST_CHECK_LOW);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q  <= '0;
            state_q <= ST_LOW;
            cnt_q   <= '0;
            dout_q  <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            busy_q  <= busy_d;
        end
    end

    assign io.dout = dout_q;
    assign io.rise = rise_q;
    assign io.fall = fall_q;
    assign io.busy = busy_q;

endmodule

// File: tb/tb_debounce_sync.sv
// Directed bench for debounce_sync at default parameters (5-cycle capture-to-output latency).
// Step n in each task means "sampled 1 time unit after the n-th edge following the stimulus change".
module tb_debounce_sync;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    debounce_sync_if dif ();

    debounce_sync #(
        .SYNC_STAGES   (2),
        .STABLE_CYCLES (4),
        .CNT_WIDTH     (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .io    (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        dif.din = 1'b1;
        for (int n = 0; n < 3; n++) begin
            tick();
            total += 4;
            if (dif.dout !== 1'b0) begin bad++; $display("FAIL reset_dout cyc=%0d got=%b want=0", n, dif.dout); end
            if (dif.rise !== 1'b0) begin bad++; $display("FAIL reset_rise cyc=%0d got=%b want=0", n, dif.rise); end
            if (dif.fall !== 1'b0) begin bad++; $display("FAIL reset_fall cyc=%0d got=%b want=0", n, dif.fall); end
            if (dif.busy !== 1'b0) begin bad++; $display("FAIL reset_busy cyc=%0d got=%b want=0", n, dif.busy); end
        end
        dif.din = 1'b0;
        tick();
        reset = 1'b0;
        for (int n = 0; n < 4; n++) tick();
        total++;
        if (dif.dout !== 1'b0) begin bad++; $display("FAIL idle_low got=%b want=0", dif.dout); end
    endtask

    task automatic test_clean_rise();
        logic exp_busy, exp_dout, exp_rise;
        dif.din = 1'b1;
        for (int n = 0; n <= 7; n++) begin
            tick();
            exp_busy = (n >= 2 && n <= 4);
            exp_dout = (n >= 5);
            exp_rise = (n == 5);
            total += 4;
            if (dif.busy !== exp_busy) begin bad++; $display("FAIL rise_busy n=%0d got=%b want=%b", n, dif.busy, exp_busy); end
            if (dif.dout !== exp_dout) begin bad++; $display("FAIL rise_dout n=%0d got=%b want=%b", n, dif.dout, exp_dout); end
            if (dif.rise !== exp_rise) begin bad++; $display("FAIL rise_strobe n=%0d got=%b want=%b", n, dif.rise, exp_rise); end
            if (dif.fall !== 1'b0)     begin bad++; $display("FAIL rise_fall n=%0d got=%b want=0", n, dif.fall); end
        end
    endtask

    task automatic test_bounce();
        logic exp_busy;
        for (int n = 0; n <= 8; n++) begin
            dif.din = (n < 3) ? 1'b0 : 1'b1;
            tick();
            exp_busy = (n >= 2 && n <= 4);
            total += 3;
            if (dif.busy !== exp_busy) begin bad++; $display("FAIL bounce_busy n=%0d got=%b want=%b", n, dif.busy, exp_busy); end
            if (dif.dout !== 1'b1)     begin bad++; $display("FAIL bounce_dout n=%0d got=%b want=1", n, dif.dout); end
            if (dif.fall !== 1'b0)     begin bad++; $display("FAIL bounce_fall n=%0d got=%b want=0", n, dif.fall); end
        end
    endtask

    task automatic test_clean_fall();
        logic exp_dout, exp_fall, exp_busy;
        int   falls;
        falls   = 0;
        dif.din = 1'b0;
        for (int n = 0; n < 10; n++) begin
            tick();
            exp_dout = (n < 5);
            exp_fall = (n == 5);
            exp_busy = (n >= 2 && n <= 4);
            if (dif.fall === 1'b1) falls++;
            total += 4;
            if (dif.dout !== exp_dout) begin bad++; $display("FAIL fall_dout n=%0d got=%b want=%b", n, dif.dout, exp_dout); end
            if (dif.fall !== exp_fall) begin bad++; $display("FAIL fall_strobe n=%0d got=%b want=%b", n, dif.fall, exp_fall); end
            if (dif.busy !== exp_busy) begin bad++; $display("FAIL fall_busy n=%0d got=%b want=%b", n, dif.busy, exp_busy); end
            if (dif.rise !== 1'b0)     begin bad++; $display("FAIL fall_rise n=%0d got=%b want=0", n, dif.rise); end
        end
        total++;
        if (falls != 1) begin bad++; $display("FAIL fall_count got=%0d want=1", falls); end
    endtask

    task automatic test_reset_mid();
        logic exp_dout, exp_rise;
        dif.din = 1'b1;
        for (int n = 0; n <= 3; n++) tick();
        // counter now holds 2; reset straddles the edge that would have completed the rise
        reset = 1'b1;
        for (int n = 0; n < 3; n++) begin
            tick();
            total += 3;
            if (dif.rise !== 1'b0) begin bad++; $display("FAIL mid_rise cyc=%0d got=%b want=0", n, dif.rise); end
            if (dif.dout !== 1'b0) begin bad++; $display("FAIL mid_dout cyc=%0d got=%b want=0", n, dif.dout); end
            if (dif.busy !== 1'b0) begin bad++; $display("FAIL mid_busy cyc=%0d got=%b want=0", n, dif.busy); end
        end
        reset = 1'b0;
        for (int n = 0; n <= 7; n++) begin
            tick();
            exp_dout = (n >= 5);
            exp_rise = (n == 5);
            total += 2;
            if (dif.dout !== exp_dout) begin bad++; $display("FAIL post_dout n=%0d got=%b want=%b", n, dif.dout, exp_dout); end
            if (dif.rise !== exp_rise) begin bad++; $display("FAIL post_rise n=%0d got=%b want=%b", n, dif.rise, exp_rise); end
        end
    endtask

    task automatic test_glitch_restart();
        logic exp_dout, exp_rise, exp_busy;
        int   rises;
        dif.din = 1'b0;
        for (int n = 0; n < 10; n++) tick();
        total++;
        if (dif.dout !== 1'b0) begin bad++; $display("FAIL glitch_pre got=%b want=0", dif.dout); end
        rises = 0;
        for (int n = 0; n < 15; n++) begin
            dif.din = (n == 2) ? 1'b0 : 1'b1;
            tick();
            exp_dout = (n >= 8);
            exp_rise = (n == 8);
            exp_busy = (n == 2 || n == 3 || (n >= 5 && n <= 7));
            if (dif.rise === 1'b1) rises++;
            total += 3;
            if (dif.dout !== exp_dout) begin bad++; $display("FAIL glitch_dout n=%0d got=%b want=%b", n, dif.dout, exp_dout); end
            if (dif.rise !== exp_rise) begin bad++; $display("FAIL glitch_rise n=%0d got=%b want=%b", n, dif.rise, exp_rise); end
            if (dif.busy !== exp_busy) begin bad++; $display("FAIL glitch_busy n=%0d got=%b want=%b", n, dif.busy, exp_busy); end
        end
        total++;
        if (rises != 1) begin bad++; $display("FAIL glitch_rise_count got=%0d want=1", rises); end
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        reset   = 1'b1;
        dif.din = 1'b0;
        test_reset();
        test_clean_rise();
        test_bounce();
        test_clean_fall();
        test_reset_mid();
        test_glitch_restart();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
